// File: rtl/sobel_window_scheduler.sv
// Streaming 3x3 window scheduler for a combinational RGB565 Sobel filter.
// Holds two previous rows in line buffers, assembles the window and registers
// the filter result together with its centre coordinates.
module sobel_window_scheduler #(
   parameter int unsigned IMG_WIDTH  = 320,
   parameter int unsigned IMG_HEIGHT = 240,
   parameter int unsigned XW         = $clog2(IMG_WIDTH),
   parameter int unsigned YW         = $clog2(IMG_HEIGHT)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic          in_sof,
   input  logic [15:0]   in_pixel,
   output logic [143:0]  win_data,
   input  logic [15:0]   filt_pixel,
   output logic          out_valid,
   output logic [15:0]   out_pixel,
   output logic [XW-1:0] out_x,
   output logic [YW-1:0] out_y,
   output logic          frame_done
);

   localparam int unsigned   PW     = 16;
   localparam int unsigned   NWIN   = 9;
   localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

   state_t        state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [PW-1:0] win_q [NWIN];
   logic [PW-1:0] win_d [NWIN];
   logic          pend_q, pend_d;
   logic          pend_last_q, pend_last_d;
   logic [XW-1:0] pend_x_q, pend_x_d;
   logic [YW-1:0] pend_y_q, pend_y_d;
   logic          out_valid_q, out_valid_d;
   logic          frame_done_q, frame_done_d;
   logic [PW-1:0] out_pixel_q, out_pixel_d;
   logic [XW-1:0] out_x_q, out_x_d;
   logic [YW-1:0] out_y_q, out_y_d;

   logic [PW-1:0] lb_a [IMG_WIDTH];
   logic [PW-1:0] lb_b [IMG_WIDTH];

   logic          sof;
   logic          accept;
   logic          row_end;
   logic          frame_end;
   logic [XW-1:0] cur_x;
   logic [YW-1:0] cur_y;
   logic [PW-1:0] rd_a;
   logic [PW-1:0] rd_b;

   // Pixel qualification: sof restarts at (0,0) from any state, IDLE drops the rest.
   always_comb begin
      sof       = in_valid & in_sof;
      accept    = sof | (in_valid & (state_q != S_IDLE));
      cur_x     = sof ? '0 : x_q;
      cur_y     = sof ? '0 : y_q;
      row_end   = (cur_x == X_LAST);
      frame_end = row_end && (cur_y == Y_LAST);
      rd_a      = lb_a[cur_x];
      rd_b      = lb_b[cur_x];
   end

   // Line buffers rotate B into A and the new pixel into B (read-before-write).
   always_ff @(posedge clk) begin
      if (accept) begin
         lb_a[cur_x] <= rd_b;
         lb_b[cur_x] <= in_pixel;
      end
   end

   // Next-state, counters, window shift and output capture.
   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      win_d        = win_q;
      pend_d       = 1'b0;
      pend_last_d  = 1'b0;
      pend_x_d     = pend_x_q;
      pend_y_d     = pend_y_q;
      out_valid_d  = pend_q;
      frame_done_d = pend_q & pend_last_q;
      out_pixel_d  = out_pixel_q;
      out_x_d      = out_x_q;
      out_y_d      = out_y_q;

      if (pend_q) begin
         out_pixel_d = filt_pixel;
         out_x_d     = pend_x_q;
         out_y_d     = pend_y_q;
      end

      unique case (state_q)
         S_IDLE:  if (accept) state_d = S_FILL;
         S_FILL: begin
            if (sof)                                          state_d = S_FILL;
            else if (accept && row_end && cur_y == YW'(1))    state_d = S_RUN;
         end
         S_RUN: begin
            if (sof)                        state_d = S_FILL;
            else if (accept && frame_end)   state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         win_d[0] = win_q[1];
         win_d[1] = win_q[2];
         win_d[2] = rd_a;
         win_d[3] = win_q[4];
         win_d[4] = win_q[5];
         win_d[5] = rd_b;
         win_d[6] = win_q[7];
         win_d[7] = win_q[8];
         win_d[8] = in_pixel;

         pend_d      = (cur_x >= XW'(2)) && (cur_y >= YW'(2));
         pend_last_d = frame_end;
         pend_x_d    = cur_x - XW'(1);
         pend_y_d    = cur_y - YW'(1);

         if (row_end) begin
            x_d = '0;
            y_d = frame_end ? '0 : cur_y + YW'(1);
         end else begin
            x_d = cur_x + XW'(1);
            y_d = cur_y;
         end
      end
   end

   // State and datapath registers; line buffers are primed by FILL instead of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         x_q          <= '0;
         y_q          <= '0;
         win_q        <= '{default: '0};
         pend_q       <= 1'b0;
         pend_last_q  <= 1'b0;
         pend_x_q     <= '0;
         pend_y_q     <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         out_pixel_q  <= '0;
         out_x_q      <= '0;
         out_y_q      <= '0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         win_q        <= win_d;
         pend_q       <= pend_d;
         pend_last_q  <= pend_last_d;
         pend_x_q     <= pend_x_d;
         pend_y_q     <= pend_y_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
         out_pixel_q  <= out_pixel_d;
         out_x_q      <= out_x_d;
         out_y_q      <= out_y_d;
      end
   end

   // Flatten the window: entry i = row*3+col, row 0 oldest line, col 0 oldest column.
   always_comb begin
      win_data = '0;
      for (int i = 0; i < NWIN; i++) win_data[PW*i +: PW] = win_q[i];
   end

   assign out_valid  = out_valid_q;
   assign frame_done = frame_done_q;
   assign out_pixel  = out_pixel_q;
   assign out_x      = out_x_q;
   assign out_y      = out_y_q;

endmodule

// File: tb/tb_sobel_window_scheduler.sv
// Bench for sobel_window_scheduler on an 8x6 image with an ideal Sobel model
// driving filt_pixel and a scoreboard of expected output pixels.
module tb_sobel_window_scheduler;

   localparam int unsigned W  = 8;
   localparam int unsigned H  = 6;
   localparam int unsigned XW = 3;
   localparam int unsigned YW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_sof;
   logic [15:0]   in_pixel;
   logic [143:0]  win_data;
   logic [15:0]   filt_pixel;
   logic          out_valid;
   logic [15:0]   out_pixel;
   logic [XW-1:0] out_x;
   logic [YW-1:0] out_y;
   logic          frame_done;

   sobel_window_scheduler #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
      .in_pixel(in_pixel), .win_data(win_data), .filt_pixel(filt_pixel),
      .out_valid(out_valid), .out_pixel(out_pixel), .out_x(out_x),
      .out_y(out_y), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          x;
      int          y;
      logic [15:0] pix;
      logic        last;
      int          cyc;
   } exp_t;

   typedef struct {
      int pat;
      int gap;
      int extra;
      int exp_outs;
      int exp_done;
   } vec_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   logic [15:0] img [H][W];
   int          cyc    = 0;
   int          n_chk  = 0;
   int          n_pass = 0;
   int          n_out  = 0;
   int          n_done = 0;

   function automatic logic [15:0] sobel_f(input logic [143:0] w);
      int p[9];
      int gx, gy, s;
      for (int i = 0; i < 9; i++) p[i] = int'(w[16*i +: 16]);
      gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
      gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
      if (gx < 0) gx = -gx;
      if (gy < 0) gy = -gy;
      s = gx + gy;
      if (s > 65535) s = 65535;
      return 16'(s);
   endfunction

   assign filt_pixel = sobel_f(win_data);

   function automatic logic [15:0] pix_of(input int pat, input int x, input int y);
      int v;
      case (pat)
         0: return 16'hF800;
         1: return (y <= 2) ? 16'hF800 : 16'h0000;
         2: return (x >= 5) ? 16'h0000 : 16'hFD68;
         default: begin
            v = (x * 131 + y * 977 + 7) * 40503;
            return 16'(v ^ (v >>> 11));
         end
      endcase
   endfunction

   function automatic logic [143:0] model_win(input int x, input int y);
      logic [143:0] r;
      r = '0;
      for (int rr = 0; rr < 3; rr++)
         for (int cc = 0; cc < 3; cc++)
            r[16*(rr*3+cc) +: 16] = img[y-2+rr][x-2+cc];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   // Cycle counter: value k after the k-th rising edge.
   always @(posedge clk) cyc++;

   // Output monitor: pop the scoreboard on each strobe, flag missing or stray outputs.
   always @(negedge clk) begin
      if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
         chk("missing_out", 144'(0), 144'(sbq[0].cyc));
         void'(sbq.pop_front());
      end
      if (out_valid) begin
         n_out++;
         if (frame_done) n_done++;
         if (sbq.size() == 0) chk("spurious_out", 144'({out_x, out_y}), 144'(0));
         else begin
            mon_e = sbq.pop_front();
            chk("out_cycle", 144'(cyc), 144'(mon_e.cyc));
            chk("out_x", 144'(out_x), 144'(mon_e.x));
            chk("out_y", 144'(out_y), 144'(mon_e.y));
            chk("out_pixel", 144'(out_pixel), 144'(mon_e.pix));
            chk("frame_done", 144'(frame_done), 144'(mon_e.last));
         end
      end else if (frame_done) begin
         chk("stray_frame_done", 144'(frame_done), 144'(0));
      end
   end

   task automatic step(input logic v, input logic sof, input logic [15:0] p);
      in_valid = v;
      in_sof   = sof;
      in_pixel = p;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic send_pixel(input int x, input int y, input logic [15:0] p, input logic sof);
      logic [143:0] mw;
      exp_t e;
      step(1'b1, sof, p);
      img[y][x] = p;
      if (x >= 2 && y >= 2) begin
         mw = model_win(x, y);
         chk("win_data", win_data, mw);
         e.x    = x - 1;
         e.y    = y - 1;
         e.pix  = sobel_f(mw);
         e.last = (x == W-1) && (y == H-1);
         e.cyc  = cyc + 1;
         sbq.push_back(e);
      end
   endtask

   task automatic send_frame(input int pat, input int gap, input int npix);
      int x, y;
      for (int i = 0; i < npix; i++) begin
         x = i % W;
         y = i / W;
         send_pixel(x, y, pix_of(pat, x, y), i == 0);
         if (gap != 0) step(1'b0, 1'(($urandom % 2)), 16'($urandom));
      end
   endtask

   task automatic drain();
      repeat (4) step(1'b0, 1'b0, 16'h0);
      chk("scoreboard_empty", 144'(sbq.size()), 144'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[6];
      int   base_out, base_done;

      vecs[0] = '{pat: 0, gap: 0, extra: 4, exp_outs: 24, exp_done: 1};
      vecs[1] = '{pat: 1, gap: 0, extra: 0, exp_outs: 24, exp_done: 1};
      vecs[2] = '{pat: 2, gap: 0, extra: 0, exp_outs: 24, exp_done: 1};
      vecs[3] = '{pat: 3, gap: 0, extra: 2, exp_outs: 24, exp_done: 1};
      vecs[4] = '{pat: 3, gap: 1, extra: 0, exp_outs: 24, exp_done: 1};
      vecs[5] = '{pat: 0, gap: 1, extra: 3, exp_outs: 24, exp_done: 1};

      reset    = 1'b1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_pixel = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 144'(out_valid), 144'(0));
      chk("rst_frame_done", 144'(frame_done), 144'(0));
      chk("rst_out_pixel", 144'(out_pixel), 144'(0));
      chk("rst_out_x", 144'(out_x), 144'(0));
      chk("rst_out_y", 144'(out_y), 144'(0));
      chk("rst_win_data", win_data, 144'(0));
      reset = 1'b0;

      // Pixels before the first sof are ignored.
      base_out = n_out;
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 16'($urandom));
      repeat (3) step(1'b0, 1'b0, 16'h0);
      chk("pre_sof_outputs", 144'(n_out - base_out), 144'(0));
      chk("pre_sof_win", win_data, 144'(0));

      // Full frames from the vector table.
      for (int t = 0; t < 6; t++) begin
         base_out  = n_out;
         base_done = n_done;
         send_frame(vecs[t].pat, vecs[t].gap, W*H);
         for (int k = 0; k < vecs[t].extra; k++) step(1'b1, 1'b0, 16'($urandom));
         drain();
         chk($sformatf("frame%0d_outputs", t), 144'(n_out - base_out), 144'(vecs[t].exp_outs));
         chk($sformatf("frame%0d_done", t), 144'(n_done - base_done), 144'(vecs[t].exp_done));
      end

      // sof reasserted where pixel (3,3) would be: 7 old outputs then a full new frame.
      base_out = n_out;
      send_frame(3, 0, 3*W + 3);
      send_frame(0, 0, W*H);
      drain();
      chk("restart_outputs", 144'(n_out - base_out), 144'(7 + 24));

      // Reset mid-RUN with an output pending.
      send_frame(3, 0, 3*W + 4);
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      sbq.delete();
      chk("midrst_out_valid", 144'(out_valid), 144'(0));
      chk("midrst_frame_done", 144'(frame_done), 144'(0));
      chk("midrst_out_x", 144'(out_x), 144'(0));
      chk("midrst_out_y", 144'(out_y), 144'(0));
      chk("midrst_out_pixel", 144'(out_pixel), 144'(0));
      chk("midrst_win_data", win_data, 144'(0));
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      base_out = n_out;
      step(1'b0, 1'b0, 16'h0);
      step(1'b0, 1'b0, 16'h0);
      chk("post_rst_quiet", 144'(n_out - base_out), 144'(0));
      base_out  = n_out;
      base_done = n_done;
      send_frame(3, 0, W*H);
      drain();
      chk("post_rst_outputs", 144'(n_out - base_out), 144'(24));
      chk("post_rst_done", 144'(n_done - base_done), 144'(1));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sobel_window_scheduler.md
# sobel_window_scheduler

Streaming controller that sequences the combinational RGB565 Sobel filter across a camera frame. It accepts one RGB565 pixel per valid cycle in raster order and keeps the two previous image rows in line buffers. It assembles the 3×3 neighbourhood, drives it to the filter's nine-pixel window input, and registers the filter result as an output pixel stream with centre coordinates. Instantiated between the camera capture path and the edge-image consumer.

## Interface
- IMG_WIDTH, 320, pixels per line (≥3)
- IMG_HEIGHT, 240, lines per frame (≥3)
- XW, $clog2(IMG_WIDTH), column counter width (derived)
- YW, $clog2(IMG_HEIGHT), row counter width (derived)

- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  pixel present this cycle; no backpressure
- in_sof  in  1  qualifies in_valid: this pixel is (0,0) of a new frame
- in_pixel  in  16  RGB565 pixel
- win_data  out  144  window to filter; data[i] = win_data[16*i +: 16], i = row*3+col, row 0 = top (oldest line), col 0 = left (oldest column)
- filt_pixel  in  16  combinational filter result for win_data
- out_valid  out  1  one-cycle strobe per interior output pixel
- out_pixel  out  16  registered filt_pixel
- out_x  out  XW  centre column of out_pixel
- out_y  out  YW  centre row of out_pixel
- frame_done  out  1  one-cycle pulse with the last output of a frame

## Operation
- States: IDLE (wait for in_valid&in_sof), FILL (rows 0–1, no output possible), RUN (rows ≥2), back to IDLE after the last pixel (IMG_WIDTH-1, IMG_HEIGHT-1).
- In IDLE, in_valid without in_sof is ignored. in_valid&in_sof in any state restarts: that pixel is (0,0), state → FILL.
- Counters x,y: each accepted pixel advances x; at x=IMG_WIDTH-1, x→0 and y increments. Pixels after (W-1,H-1) and before the next sof are dropped.
- Line buffers A (row y-2), B (row y-1), depth IMG_WIDTH × 16. On accepting pixel p at column x: read A[x], B[x]; write A[x]←B[x], B[x]←p.
- Window shift on each accepted pixel: columns 0←1, 1←2; new column 2 = {A[x] (data[2]), B[x] (data[5]), p (data[8])}.
- Output condition: accepted pixel (x,y) with x≥2 and y≥2 produces centre (x-1, y-1). Result: (IMG_WIDTH-2)·(IMG_HEIGHT-2) outputs per frame. Border centres produce no output.
- Window columns at x=0,1 contain stale data. win_data is still driven, but nothing is captured.
- frame_done asserts with the output for centre (W-2, H-2).

## Timing
- Reset values: out_valid=0, frame_done=0, out_pixel=0, out_x=0, out_y=0, win_data=0, state IDLE, x=y=0. Line-buffer contents are undefined and need no reset; FILL re-primes them.
- Latency: pixel accepted at edge k updates win_data at edge k. filt_pixel settles within cycle k→k+1. At edge k+1, out_pixel/out_x/out_y are captured and out_valid is high for that one cycle.
- Throughput: one pixel per clock. in_valid gaps pass through unchanged; out_valid follows in_valid with 2-edge delay and the same gaps.
- Reads of A[x]/B[x] and writes in the same cycle are read-before-write: the old value is used.
- Reset mid-frame: all outputs return to reset values immediately. An in-flight out_valid is cancelled.
- sof mid-frame: the pending output from the previous accepted pixel still completes the next cycle. No further outputs from the old frame.

## Test plan
- IMG_WIDTH=8, IMG_HEIGHT=6, continuous frame of 0xF800 -> exactly 24 out_valid strobes, centres (1..6, 1..4) in raster order, out_pixel=0x0000 with an ideal filter model, frame_done coincident with (6,4).
- Rows 0–2 = 0xF800, rows 3–5 = 0x0000 -> at centre (3,2), win_data data[0..5]=0xF800 and data[6..8]=0x0000. Rows 3–5 = 0xFD68 with left columns 0xFD68 and column 5+ = 0x0000 -> at centre (4,2), data[2],[5],[8]=0x0000 and the rest 0xFD68.
- Latency: pixel (2,2) accepted at edge k -> out_valid at edge k+1 with out_x=1, out_y=1 and out_pixel equal to filt_pixel presented during cycle k.
- in_valid high every other cycle across a full frame -> still 24 outputs, each exactly 2 edges after its triggering pixel, and identical values to the continuous run.
- in_sof reasserted at pixel (3,3) -> no outputs until new (2,2). Pixels before the first sof after reset are ignored (no out_valid).
- reset asserted mid-RUN with out_valid pending -> out_valid, frame_done and out_x/out_y are 0 asynchronously. The next sof frame yields the full 24 correct outputs.
